// File: rtl/phase_meter_pkg.sv
// Shared FSM state type and counter saturation helper for the phase meter.
package phase_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    // All-ones value of a counter of the given width (widths up to 64 bits).
    function automatic logic [63:0] cnt_sat(input int unsigned width);
        if (width >= 64) begin
            return '1;
        end
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/phase_meter_edge_sync.sv
// Input synchroniser followed by a one-cycle strobe on the selected edge.
module edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic edge_sel,
    input  logic din,
    output logic stb
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    always_comb begin
        stb = 1'b0;
        if (edge_sel) begin
            stb = sync[SYNC_STAGES-1] & ~prev;
        end else begin
            stb = ~sync[SYNC_STAGES-1] & prev;
        end
    end

endmodule

// File: rtl/phase_meter.sv
// Reference period and per-channel phase delay meter, counted in clk cycles.
module phase_meter
    import phase_meter_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned CH          = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                edge_sel,
    input  logic                ref_in,
    input  logic [CH-1:0]       sig_in,
    output logic [WIDTH-1:0]    period,
    output logic [CH*WIDTH-1:0] phase,
    output logic [CH-1:0]       ch_hit,
    output logic                result_valid,
    output logic                overflow
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(cnt_sat(WIDTH));

    state_t                     state;
    logic [WIDTH-1:0]           cnt;
    logic [CH-1:0][WIDTH-1:0]   shadow;
    logic [CH-1:0]              hit_sh;
    logic                       ref_stb;
    logic [CH-1:0]              sig_stb;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .edge_sel (edge_sel),
        .din      (ref_in),
        .stb      (ref_stb)
    );

    for (genvar g = 0; g < CH; g++) begin : g_sig
        edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sig_sync (
            .clk      (clk),
            .rst_n    (rst_n),
            .edge_sel (edge_sel),
            .din      (sig_in[g]),
            .stb      (sig_stb[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            shadow       <= '0;
            hit_sh       <= '0;
            period       <= '0;
            phase        <= '0;
            ch_hit       <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (!en) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        cnt   <= '0;
                        state <= ARM;
                    end
                    ARM: begin
                        // A channel edge coincident with the reference edge opens the window at phase 0.
                        if (ref_stb) begin
                            cnt    <= WIDTH'(1);
                            shadow <= '0;
                            hit_sh <= sig_stb;
                            state  <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (ref_stb) begin
                            period <= cnt;
                            for (int unsigned i = 0; i < CH; i++) begin
                                phase[i*WIDTH +: WIDTH] <= hit_sh[i] ? shadow[i] : '0;
                            end
                            ch_hit       <= hit_sh;
                            overflow     <= 1'b0;
                            result_valid <= 1'b1;
                            cnt          <= WIDTH'(1);
                            shadow       <= '0;
                            hit_sh       <= sig_stb;
                        end else if (cnt == CNT_MAX) begin
                            overflow <= 1'b1;
                            state    <= ARM;
                        end else begin
                            cnt <= cnt + WIDTH'(1);
                            for (int unsigned i = 0; i < CH; i++) begin
                                if (sig_stb[i] && !hit_sh[i]) begin
                                    shadow[i] <= cnt;
                                    hit_sh[i] <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_phase_meter.sv
// Scoreboard bench: a WIDTH=16 and a WIDTH=8 meter share one stimulus stream.
module tb_phase_meter;

    localparam int CH = 4;

    typedef struct packed {
        logic [31:0]      per;
        logic [CH*32-1:0] ph;
        logic [CH-1:0]    hit;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          en;
    logic          edge_sel;
    logic          ref_in;
    logic [CH-1:0] sig_in;

    logic [15:0]      period16;
    logic [CH*16-1:0] phase16;
    logic [CH-1:0]    hit16;
    logic             rv16;
    logic             ovf16;
    logic [7:0]       period8;
    logic [CH*8-1:0]  phase8;
    logic [CH-1:0]    hit8;
    logic             rv8;
    logic             ovf8;

    phase_meter #(.WIDTH(16), .CH(CH), .SYNC_STAGES(2)) dut16 (
        .clk(clk), .rst_n(rst_n), .en(en), .edge_sel(edge_sel), .ref_in(ref_in), .sig_in(sig_in),
        .period(period16), .phase(phase16), .ch_hit(hit16), .result_valid(rv16), .overflow(ovf16)
    );

    phase_meter #(.WIDTH(8), .CH(CH), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .edge_sel(edge_sel), .ref_in(ref_in), .sig_in(sig_in),
        .period(period8), .phase(phase8), .ch_hit(hit8), .result_valid(rv8), .overflow(ovf8)
    );

    int   checks   = 0;
    int   failures = 0;
    int   pub16    = 0;
    int   pub8     = 0;
    res_t q16[$];
    res_t q8[$];
    res_t hold[2];

    // Reference model: event times in cycles, one context per instance width.
    int          cyc = 0;
    bit          en_m;
    bit          av[2];
    int          anc[2];
    int          first[2][CH];
    int          mx[2] = '{65535, 255};
    bit          prev_r;
    bit [CH-1:0] prev_s;

    int s1a[CH]  = '{25, 0, 99, -1};
    int none[CH] = '{-1, -1, -1, -1};
    int s2a[CH]  = '{10, -1, -1, -1};
    int s2b[CH]  = '{40, -1, -1, -1};
    int rnd[CH];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic cmp_dut(input string tag, input int k, input res_t e);
        logic [31:0]      per;
        logic [CH*32-1:0] ph;
        logic [CH-1:0]    hit;
        ph = '0;
        if (k == 0) begin
            per = {16'd0, period16};
            hit = hit16;
            for (int i = 0; i < CH; i++) ph[i*32 +: 32] = {16'd0, phase16[i*16 +: 16]};
        end else begin
            per = {24'd0, period8};
            hit = hit8;
            for (int i = 0; i < CH; i++) ph[i*32 +: 32] = {24'd0, phase8[i*8 +: 8]};
        end
        chk({tag, "_period"}, per, e.per);
        chk({tag, "_phase"}, ph, e.ph);
        chk({tag, "_ch_hit"}, hit, e.hit);
    endtask

    task automatic model_ref(input int t);
        res_t e;
        for (int k = 0; k < 2; k++) begin
            if (av[k] && (t - anc[k]) <= mx[k]) begin
                e.per = 32'(t - anc[k]);
                e.ph  = '0;
                e.hit = '0;
                for (int i = 0; i < CH; i++) begin
                    if (first[k][i] >= 0) begin
                        e.hit[i]        = 1'b1;
                        e.ph[i*32 +: 32] = 32'(first[k][i]);
                    end
                end
                if (k == 0) q16.push_back(e);
                else        q8.push_back(e);
                hold[k] = e;
            end
            av[k]  = 1'b1;
            anc[k] = t;
            for (int i = 0; i < CH; i++) first[k][i] = -1;
        end
    endtask

    task automatic model_sig(input int i, input int t);
        for (int k = 0; k < 2; k++) begin
            if (av[k] && first[k][i] < 0) first[k][i] = t - anc[k];
        end
    endtask

    task automatic step(input bit r, input bit [CH-1:0] s);
        bit act = edge_sel;
        ref_in = r ? act : ~act;
        for (int i = 0; i < CH; i++) sig_in[i] = s[i] ? act : ~act;
        if (en_m) begin
            if (r && !prev_r) model_ref(cyc);
            for (int i = 0; i < CH; i++) if (s[i] && !prev_s[i]) model_sig(i, cyc);
        end
        prev_r = r;
        prev_s = s;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, '0);
    endtask

    task automatic set_en(input bit v);
        en   = v;
        en_m = v;
        if (!v) begin
            av[0] = 1'b0;
            av[1] = 1'b0;
        end
    endtask

    task automatic run_window(input int per, input int la[CH], input int lb[CH], input int cut);
        for (int c = 0; c < per; c++) begin
            bit [CH-1:0] s;
            if (c == cut) set_en(1'b0);
            for (int i = 0; i < CH; i++) s[i] = (la[i] == c) || (lb[i] == c);
            step(c == 0, s);
        end
    endtask

    task automatic chk_reset(input string tag);
        cmp_dut({tag, "_w16"}, 0, '0);
        cmp_dut({tag, "_w8"}, 1, '0);
        chk({tag, "_w16_valid"}, rv16, 0);
        chk({tag, "_w8_valid"}, rv8, 0);
        chk({tag, "_w16_overflow"}, ovf16, 0);
        chk({tag, "_w8_overflow"}, ovf8, 0);
    endtask

    task automatic chk_hold(input string tag);
        cmp_dut({tag, "_w16_hold"}, 0, hold[0]);
        cmp_dut({tag, "_w8_hold"}, 1, hold[1]);
    endtask

    always @(negedge clk) begin
        res_t e;
        if (rst_n === 1'b1 && rv16 === 1'b1) begin
            pub16++;
            if (q16.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL w16_unexpected_publish: got result_valid=1 required no publish");
            end else begin
                e = q16.pop_front();
                cmp_dut("w16_pub", 0, e);
                chk("w16_pub_overflow", ovf16, 0);
            end
        end
    end

    always @(negedge clk) begin
        res_t e;
        if (rst_n === 1'b1 && rv8 === 1'b1) begin
            pub8++;
            if (q8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL w8_unexpected_publish: got result_valid=1 required no publish");
            end else begin
                e = q8.pop_front();
                cmp_dut("w8_pub", 1, e);
                chk("w8_pub_overflow", ovf8, 0);
            end
        end
    end

    initial begin
        res_t s1_exp;
        int   n16;
        int   n8;
        s1_exp.per = 32'd100;
        s1_exp.ph  = {32'd0, 32'd99, 32'd0, 32'd25};
        s1_exp.hit = 4'b0111;

        rst_n    = 1'b0;
        en       = 1'b0;
        en_m     = 1'b0;
        edge_sel = 1'b0;
        ref_in   = 1'b1;
        sig_in   = '1;
        prev_r   = 1'b0;
        prev_s   = '0;
        for (int k = 0; k < 2; k++) begin
            av[k]   = 1'b0;
            anc[k]  = 0;
            hold[k] = '0;
            for (int i = 0; i < CH; i++) first[k][i] = -1;
        end

        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        idle(5);
        set_en(1'b1);
        idle(10);

        // Basic phase relationships, including a lag-0 channel and an idle channel.
        repeat (4) run_window(100, s1a, none, -1);
        cmp_dut("s1_w16_fixed", 0, s1_exp);
        cmp_dut("s1_w8_fixed", 1, s1_exp);

        // Only the first channel edge in a window counts.
        run_window(100, s2a, s2b, -1);
        run_window(100, s1a, none, -1);
        chk("s2_phase0_first_edge", {16'd0, phase16[15:0]}, 10);

        repeat (8) begin
            int per;
            per = int'($urandom_range(250, 20));
            for (int i = 0; i < CH; i++) begin
                rnd[i] = ($urandom_range(3) == 0) ? -1 : int'($urandom_range(per - 2, 0));
            end
            run_window(per, rnd, none, -1);
        end

        // Enable dropped mid-window: no publish, outputs hold, re-arm on return.
        run_window(100, s1a, none, 50);
        idle(20);
        chk_hold("en_drop");
        set_en(1'b1);
        idle(10);
        n16 = pub16;
        run_window(100, s1a, none, -1);
        chk("reen_first_ref_no_pulse", pub16, n16);
        run_window(100, s1a, none, -1);
        chk("reen_second_ref_pulse", pub16, n16 + 1);
        chk_hold("reen");

        // Asynchronous reset in the middle of a window.
        run_window(100, s1a, none, -1);
        idle(50);
        chk_hold("pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("async_reset");
        av[0]   = 1'b0;
        av[1]   = 1'b0;
        hold[0] = '0;
        hold[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);
        n16 = pub16;
        run_window(100, s1a, none, -1);
        chk("post_reset_first_ref_no_pulse", pub16, n16);
        repeat (2) run_window(100, s1a, none, -1);
        cmp_dut("post_reset_w16", 0, s1_exp);

        // Overflow on the 8-bit instance, then recovery with a shorter period.
        run_window(300, s1a, none, -1);
        n8 = pub8;
        repeat (2) run_window(300, s1a, none, -1);
        run_window(200, s1a, none, -1);
        chk("ovf_w8_sticky", ovf8, 1);
        chk("ovf_w16_clear", ovf16, 0);
        chk("ovf_w8_no_publish", pub8, n8);
        repeat (2) run_window(200, s1a, none, -1);
        chk("ovf_w8_recover_period", {24'd0, period8}, 200);
        chk("ovf_w8_recover_flag", ovf8, 0);
        chk("ovf_w16_period", {16'd0, period16}, 200);

        // Rising-edge mode with inverted stimulus must give identical results.
        set_en(1'b0);
        idle(10);
        edge_sel = 1'b1;
        idle(10);
        set_en(1'b1);
        idle(10);
        repeat (4) run_window(100, s1a, none, -1);
        cmp_dut("rise_w16_fixed", 0, s1_exp);
        cmp_dut("rise_w8_fixed", 1, s1_exp);

        step(1'b1, '0);
        idle(10);
        chk("w16_queue_drained", q16.size(), 0);
        chk("w8_queue_drained", q8.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
